// File: rtl/gb_lcd_capture_pkg.sv
// Shared constants and state encoding for the Game Boy LCD capture path and
// the upscaler that reads the line RAM ring.
package gb_lcd_capture_pkg;

   localparam int H_PIX   = 160;
   localparam int V_LINES = 144;
   localparam int LRAM_AW = 10;
   localparam int ROW_W   = 2;
   localparam int COL_W   = LRAM_AW - ROW_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/gb_lcd_capture_sync_edge.sv
// Multi-flop synchroniser for one asynchronous LCD control line, followed by a
// history register that yields single-clk rise/fall pulses.
module gb_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the Game Boy LCD pixel stream into a 4-row line RAM ring and tells
// the downstream upscaler when each row and its neighbours are available.
module gb_lcd_capture #(
   parameter int H_PIX       = gb_lcd_capture_pkg::H_PIX,
   parameter int V_LINES     = gb_lcd_capture_pkg::V_LINES,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gb_clk,
   input  logic       gb_hsync,
   input  logic       gb_vsync,
   input  logic [1:0] gb_data,
   output logic [9:0] lram_wa,
   output logic [1:0] lram_di,
   output logic       lram_we,
   output logic [7:0] rrow,
   output logic       r_row_inc,
   output logic       frame,
   output logic       err_short,
   output logic       err_long
);

   import gb_lcd_capture_pkg::*;

   localparam logic [COL_W-1:0] COL_END  = COL_W'(H_PIX);
   localparam logic [7:0]       ROW_LAST = 8'(V_LINES - 1);

   logic pix_edge;
   logic hs_edge;
   logic vs_level;
   logic pclk_level_unused;
   logic pclk_rise_unused;
   logic hs_level_unused;
   logic hs_fall_unused;
   logic vs_rise_unused;
   logic vs_fall_unused;

   gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (gb_clk),
      .level (pclk_level_unused),
      .rise  (pclk_rise_unused),
      .fall  (pix_edge)
   );

   gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hsync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (gb_hsync),
      .level (hs_level_unused),
      .rise  (hs_edge),
      .fall  (hs_fall_unused)
   );

   gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (gb_vsync),
      .level (vs_level),
      .rise  (vs_rise_unused),
      .fall  (vs_fall_unused)
   );

   // Data takes the same number of flops as gb_clk so the shade seen with a
   // detected falling edge is the one sampled alongside that edge.
   logic [1:0] data_sync [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            data_sync[i] <= '0;
         end
      end else begin
         data_sync[0] <= gb_data;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   cap_state_t       state;
   logic [COL_W-1:0] col;
   logic [7:0]       wrow;
   logic             pix_ok;
   logic [COL_W-1:0] col_after;

   assign pix_ok    = pix_edge && (col < COL_END);
   assign col_after = pix_ok ? col + COL_W'(1) : col;

   // A pixel coinciding with the line end is written first; col_after then
   // counts it when judging whether the line came up short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= '0;
         wrow      <= '0;
         rrow      <= '0;
         lram_we   <= 1'b0;
         lram_wa   <= '0;
         lram_di   <= '0;
         r_row_inc <= 1'b0;
         frame     <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         lram_we   <= 1'b0;
         r_row_inc <= 1'b0;
         frame     <= 1'b0;
         case (state)
            IDLE: begin
               if (hs_edge && vs_level) begin
                  frame <= 1'b1;
                  wrow  <= '0;
                  col   <= '0;
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (pix_edge) begin
                  if (pix_ok) begin
                     lram_we <= 1'b1;
                     lram_di <= data_sync[SYNC_STAGES-1];
                     lram_wa <= {wrow[ROW_W-1:0], col};
                  end else begin
                     err_long <= 1'b1;
                  end
               end
               col <= col_after;
               if (hs_edge) begin
                  col <= '0;
                  if (vs_level) begin
                     frame <= 1'b1;
                     wrow  <= '0;
                  end else begin
                     if (col_after < COL_END) begin
                        err_short <= 1'b1;
                     end
                     if (wrow != '0) begin
                        r_row_inc <= 1'b1;
                        rrow      <= wrow - 8'd1;
                     end
                     if (wrow == ROW_LAST) begin
                        state <= FLUSH;
                     end
                     wrow <= wrow + 8'd1;
                  end
               end
            end
            FLUSH: begin
               r_row_inc <= 1'b1;
               rrow      <= ROW_LAST;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: drives LCD pin sequences and compares
// outputs and monitor tallies against hand-worked values.
module tb_gb_lcd_capture;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       gb_clk = 1'b0;
   logic       gb_hsync = 1'b0;
   logic       gb_vsync = 1'b0;
   logic [1:0] gb_data = 2'd0;
   logic [9:0] lram_wa;
   logic [1:0] lram_di;
   logic       lram_we;
   logic [7:0] rrow;
   logic       r_row_inc;
   logic       frame;
   logic       err_short;
   logic       err_long;

   int total = 0;
   int bad = 0;

   int we_count = 0;
   int inc_count = 0;
   int inc_base = 0;
   int seq_bad = 0;
   int data_bad = 0;
   int frame_count = 0;
   int both_hi = 0;
   int rf3_count = 0;
   int cap_idx = -1;
   logic [9:0] cap_wa = '0;
   logic [1:0] cap_di = '0;
   logic [9:0] last_wa = '0;
   logic [1:0] last_di = '0;
   logic [7:0] last_rrow = '0;

   int base_we, base_inc, base_seq, base_data, base_frame, base_both, base_rf3;

   always #5 clk = ~clk;

   gb_lcd_capture dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gb_clk    (gb_clk),
      .gb_hsync  (gb_hsync),
      .gb_vsync  (gb_vsync),
      .gb_data   (gb_data),
      .lram_wa   (lram_wa),
      .lram_di   (lram_di),
      .lram_we   (lram_we),
      .rrow      (rrow),
      .r_row_inc (r_row_inc),
      .frame     (frame),
      .err_short (err_short),
      .err_long  (err_long)
   );

   // Tallies write and row-ready traffic so directed steps can compare totals.
   always @(negedge clk) begin
      if (lram_we) begin
         if (we_count == cap_idx) begin
            cap_wa = lram_wa;
            cap_di = lram_di;
         end
         if (lram_di !== lram_wa[1:0]) data_bad++;
         if (lram_wa[9:8] == 2'd3) rf3_count++;
         last_wa = lram_wa;
         last_di = lram_di;
         we_count++;
      end
      if (r_row_inc) begin
         if (rrow !== 8'(inc_count - inc_base)) seq_bad++;
         last_rrow = rrow;
         inc_count++;
      end
      if (frame) frame_count++;
      if (frame && r_row_inc) both_hi++;
   end

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic c, input logic hs, input logic vs,
                                input logic [1:0] d);
      @(negedge clk);
      gb_clk   = c;
      gb_hsync = hs;
      gb_vsync = vs;
      gb_data  = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sendPixel(input logic [1:0] d);
      applyStimulus(1'b1, 1'b0, 1'b0, d);
      applyStimulus(1'b0, 1'b0, 1'b0, d);
   endtask

   task automatic sendHsync(input logic vs);
      applyStimulus(1'b0, 1'b1, vs, 2'd0);
      applyStimulus(1'b0, 1'b0, vs, 2'd0);
   endtask

   task automatic sendLine(input int n);
      for (int i = 0; i < n; i++) sendPixel(2'(i));
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n    = 1'b0;
      gb_clk   = 1'b0;
      gb_hsync = 1'b0;
      gb_vsync = 1'b0;
      gb_data  = 2'd0;
      waitNeg(2);
      rst_n = 1'b1;
      waitNeg(2);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      waitNeg(1);
      $display("[TB] reset state");
      checkOutput("rst_we", 32'(lram_we), 32'd0);
      checkOutput("rst_inc", 32'(r_row_inc), 32'd0);
      checkOutput("rst_frame", 32'(frame), 32'd0);
      checkOutput("rst_rrow", 32'(rrow), 32'd0);
      checkOutput("rst_wa", 32'(lram_wa), 32'd0);
      checkOutput("rst_err_short", 32'(err_short), 32'd0);
      checkOutput("rst_err_long", 32'(err_long), 32'd0);
      rst_n = 1'b1;
      waitNeg(2);

      $display("[TB] frame pulse and write latency");
      sendHsync(1'b1);
      waitNeg(2);
      checkOutput("frame_pulse", 32'(frame), 32'd1);
      checkOutput("frame_no_inc", 32'(r_row_inc), 32'd0);
      waitNeg(1);
      checkOutput("frame_one_clk", 32'(frame), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd3);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
      waitNeg(2);
      checkOutput("lat_we_early", 32'(lram_we), 32'd0);
      waitNeg(1);
      checkOutput("lat_we", 32'(lram_we), 32'd1);
      checkOutput("lat_wa", 32'(lram_wa), 32'h000);
      checkOutput("lat_di", 32'(lram_di), 32'd3);
      waitNeg(1);
      checkOutput("lat_we_pulse", 32'(lram_we), 32'd0);

      $display("[TB] full 144x160 frame");
      applyReset();
      base_we = we_count; base_inc = inc_count; base_seq = seq_bad;
      base_data = data_bad; base_frame = frame_count; base_both = both_hi;
      inc_base = inc_count;
      cap_idx = we_count + 5 * 160 + 7;
      sendHsync(1'b1);
      for (int r = 0; r < 144; r++) begin
         sendLine(160);
         sendHsync(1'b0);
      end
      waitNeg(6);
      checkOutput("frm_writes", 32'(we_count - base_we), 32'd23040);
      checkOutput("frm_r5c7_wa", 32'(cap_wa), 32'h107);
      checkOutput("frm_r5c7_di", 32'(cap_di), 32'd3);
      checkOutput("frm_inc_cnt", 32'(inc_count - base_inc), 32'd144);
      checkOutput("frm_rrow_seq", 32'(seq_bad - base_seq), 32'd0);
      checkOutput("frm_data", 32'(data_bad - base_data), 32'd0);
      checkOutput("frm_frames", 32'(frame_count - base_frame), 32'd1);
      checkOutput("frm_overlap", 32'(both_hi - base_both), 32'd0);
      checkOutput("frm_last_rrow", 32'(last_rrow), 32'd143);
      checkOutput("frm_err_short", 32'(err_short), 32'd0);
      checkOutput("frm_err_long", 32'(err_long), 32'd0);

      $display("[TB] long line");
      applyReset();
      base_we = we_count; base_inc = inc_count;
      sendHsync(1'b1);
      sendLine(165);
      waitNeg(4);
      checkOutput("long_writes", 32'(we_count - base_we), 32'd160);
      checkOutput("long_err_long", 32'(err_long), 32'd1);
      sendHsync(1'b0);
      sendPixel(2'd0);
      waitNeg(4);
      checkOutput("long_err_short", 32'(err_short), 32'd0);
      checkOutput("long_next_wa", 32'(last_wa), 32'h100);
      checkOutput("long_no_inc", 32'(inc_count - base_inc), 32'd0);

      $display("[TB] short line");
      applyReset();
      base_rf3 = rf3_count; base_inc = inc_count;
      sendHsync(1'b1);
      for (int r = 0; r < 3; r++) begin
         sendLine(160);
         sendHsync(1'b0);
      end
      sendLine(150);
      sendHsync(1'b0);
      sendLine(2);
      waitNeg(4);
      checkOutput("short_rf3", 32'(rf3_count - base_rf3), 32'd150);
      checkOutput("short_err_short", 32'(err_short), 32'd1);
      checkOutput("short_err_long", 32'(err_long), 32'd0);
      checkOutput("short_inc_cnt", 32'(inc_count - base_inc), 32'd3);
      checkOutput("short_last_rrow", 32'(last_rrow), 32'd2);
      checkOutput("short_next_wa", 32'(last_wa), 32'h001);

      $display("[TB] pixel coincident with hsync");
      applyReset();
      sendHsync(1'b1);
      sendLine(160);
      sendHsync(1'b0);
      sendLine(5);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      waitNeg(2);
      checkOutput("coin_we", 32'(lram_we), 32'd1);
      checkOutput("coin_wa", 32'(lram_wa), 32'h105);
      checkOutput("coin_di", 32'(lram_di), 32'd1);
      checkOutput("coin_inc", 32'(r_row_inc), 32'd1);
      checkOutput("coin_rrow", 32'(rrow), 32'd0);
      waitNeg(1);
      checkOutput("coin_inc_pulse", 32'(r_row_inc), 32'd0);
      checkOutput("coin_err_short", 32'(err_short), 32'd1);

      $display("[TB] vsync restart after 50 lines");
      applyReset();
      base_inc = inc_count; base_frame = frame_count;
      sendHsync(1'b1);
      for (int r = 0; r < 50; r++) begin
         sendLine(8);
         if (r < 49) sendHsync(1'b0);
      end
      sendHsync(1'b1);
      waitNeg(2);
      checkOutput("vrst_frame", 32'(frame), 32'd1);
      checkOutput("vrst_no_inc", 32'(r_row_inc), 32'd0);
      waitNeg(3);
      checkOutput("vrst_inc_cnt", 32'(inc_count - base_inc), 32'd48);
      checkOutput("vrst_last_rrow", 32'(last_rrow), 32'd47);
      checkOutput("vrst_frames", 32'(frame_count - base_frame), 32'd2);
      sendPixel(2'd2);
      waitNeg(4);
      checkOutput("vrst_next_wa", 32'(last_wa), 32'h000);
      checkOutput("vrst_next_di", 32'(last_di), 32'd2);

      $display("[TB] reset mid-line");
      applyReset();
      checkOutput("mid_err_cleared", 32'(err_short), 32'd0);
      sendHsync(1'b1);
      for (int r = 0; r < 10; r++) begin
         sendLine(160);
         sendHsync(1'b0);
      end
      sendLine(80);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      rst_n  = 1'b0;
      gb_clk = 1'b0;
      waitNeg(1);
      checkOutput("mid_we", 32'(lram_we), 32'd0);
      checkOutput("mid_inc", 32'(r_row_inc), 32'd0);
      checkOutput("mid_frame", 32'(frame), 32'd0);
      checkOutput("mid_rrow", 32'(rrow), 32'd0);
      checkOutput("mid_wa", 32'(lram_wa), 32'd0);
      checkOutput("mid_di", 32'(lram_di), 32'd0);
      rst_n = 1'b1;
      waitNeg(1);
      base_we = we_count; base_inc = inc_count;
      sendLine(20);
      sendHsync(1'b0);
      sendLine(10);
      waitNeg(4);
      checkOutput("mid_no_writes", 32'(we_count - base_we), 32'd0);
      checkOutput("mid_no_inc", 32'(inc_count - base_inc), 32'd0);
      sendHsync(1'b1);
      sendPixel(2'd3);
      waitNeg(4);
      checkOutput("mid_resume", 32'(we_count - base_we), 32'd1);
      checkOutput("mid_resume_wa", 32'(last_wa), 32'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gb_lcd_capture.md
GB_LCD_CAPTURE -- requirements
Module: gb_lcd_capture

Interface
REQ-001 Parameter H_PIX, default 160, pixels per line.
REQ-002 Parameter V_LINES, default 144, lines per frame.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth for LCD inputs.
REQ-004 clk  in  1  system clock; the block uses one clock only.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 gb_clk  in  1  LCD pixel clock, asynchronous to clk; data is valid at its falling edge.
REQ-007 gb_hsync  in  1  line latch; a rising edge ends the current line.
REQ-008 gb_vsync  in  1  frame marker; high at a gb_hsync rising edge marks the first line.
REQ-009 gb_data  in  2  pixel shade.
REQ-010 lram_wa  out  10  line RAM write address, {row[1:0], col[7:0]}.
REQ-011 lram_di  out  2  line RAM write data.
REQ-012 lram_we  out  1  line RAM write enable, one clk per pixel.
REQ-013 rrow  out  8  row index the consumer processes next.
REQ-014 r_row_inc  out  1  one-clk pulse: row rrow and its neighbours are in RAM.
REQ-015 frame  out  1  one-clk pulse at frame start.
REQ-016 err_short / err_long  out  1 each  sticky flags for lines with fewer or more than H_PIX pixels.

Function
REQ-017 gb_clk, gb_hsync, gb_vsync and gb_data pass through SYNC_STAGES flops, then one edge-detect register.
REQ-018 Pixel write: a synchronised gb_clk falling edge in state ACTIVE with col<H_PIX asserts lram_we for one clk, with lram_di = synchronised gb_data and lram_wa = {wrow[1:0], col}; col then increments.
REQ-019 Write latency is SYNC_STAGES+1 clk from the gb_clk edge at the pin to lram_we high.
REQ-020 States: IDLE, ACTIVE, FLUSH.
REQ-021 IDLE: ignore pixels; on an hsync edge with vsync high, pulse frame, set wrow=0 and col=0, go to ACTIVE.
REQ-022 ACTIVE, hsync edge without vsync: end the line; wrow++, col=0.
REQ-023 ACTIVE, hsync edge with vsync high: restart the frame exactly as IDLE does (pulse frame, wrow=0, col=0); no r_row_inc is issued for the aborted frame.
REQ-024 End of line with col<H_PIX sets err_short; unwritten columns keep stale data; the row still counts.
REQ-025 Pixel edges with col==H_PIX are dropped and set err_long; col saturates at H_PIX.
REQ-026 Completing row w (w>=1) pulses r_row_inc with rrow=w-1, in the clk after the hsync edge.
REQ-027 Completing row V_LINES-1 also enters FLUSH, which pulses r_row_inc with rrow=V_LINES-1 one clk later, then returns to IDLE.
REQ-028 rrow holds its value between pulses; wrow[1:0] wraps modulo 4, so the ring holds rows rrow-1..rrow+2.
REQ-029 A pixel edge and an hsync edge in the same clk: write the pixel to the old row first, then end the line.
REQ-030 frame and r_row_inc are never high in the same clk.

Reset
REQ-031 When rst_n is low: state=IDLE, col=0, wrow=0, rrow=0, lram_we=0, r_row_inc=0, frame=0, err flags=0, synchroniser and edge registers=0.
REQ-032 A reset mid-line abandons the line; writes resume only after the next vsync-qualified hsync edge.
REQ-033 Error flags clear only on reset.

Structure
REQ-034 The shared package holds: H_PIX, V_LINES, the LRAM address width (10), the row-field width (2), and the capture state encoding. The upscaler uses the same constants.
REQ-035 One sub-module, gb_sync_edge: a SYNC_STAGES synchroniser with rise/fall detection, instantiated once for each control input.

Verification
REQ-036 Frame of 144 lines x 160 pixels, gb_data = col[1:0] -> 23040 writes; row 5 col 7 is written at lram_wa=0x107 with data 3; r_row_inc pulses with rrow 0..143 in order.
REQ-037 Line 3 carries 150 pixels -> err_short=1; 150 writes at row field 3; the row counter advances normally.
REQ-038 Line 0 carries 165 pixels -> exactly 160 writes; err_long=1.
REQ-039 A vsync-qualified hsync after 50 lines -> frame pulses, wrow=0, and the next write address is 0x000.
REQ-040 rst_n low during pixel 80 of line 10 -> all outputs at reset values; no lram_we until the next frame start.
REQ-041 A pixel edge coincides with the hsync edge of row 1 -> the pixel is written to row field 1, then r_row_inc pulses with rrow=0.
